// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma byte feeder: FSM state encoding
// and the uppercase ASCII window that goes through the cipher core.
package enigma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_A = 8'h41;
   localparam logic [7:0] ASCII_Z = 8'h5A;

   function automatic logic is_letter(input logic [7:0] b);
      return (b >= ASCII_A) && (b <= ASCII_Z);
   endfunction

endpackage

// File: rtl/enigma_feeder_fifo.sv
// Input byte FIFO for enigma_feeder; pointers carry one extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module enigma_feeder_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = 1;

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/enigma_feeder.sv
// Feeds buffered bytes one at a time to an Enigma cipher core and returns results
// in order. Optional macro ENIGMA_FEEDER_PASSTHRU_EN bypasses the core for non-letters.
module enigma_feeder
   import enigma_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_data,
   output logic       core_valid,
   output logic [7:0] core_din,
   input  logic       core_done,
   input  logic [7:0] core_dout,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] m_data,
   output logic       busy,
   output logic       timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [7:0]       issue_byte;
   logic [7:0]       head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             push;

   assign s_ready = reset_n && !fifo_full;
   assign push    = s_valid && s_ready;
   assign pop     = (state == IDLE) && !fifo_empty;
   assign busy    = reset_n && ((state != IDLE) || !fifo_empty);

   enigma_feeder_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .push   (push),
      .din    (s_data),
      .pop    (pop),
      .dout   (head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         issue_byte  <= '0;
         core_valid  <= 1'b0;
         core_din    <= '0;
         m_valid     <= 1'b0;
         m_data      <= '0;
         timeout_err <= 1'b0;
      end else begin
         // Issue outputs are pulses; they only rise on the ISSUE->WAIT edge.
         core_valid <= 1'b0;
         core_din   <= '0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  issue_byte <= head;
`ifdef ENIGMA_FEEDER_PASSTHRU_EN
                  if (!is_letter(head)) begin
                     m_valid <= 1'b1;
                     m_data  <= head;
                     state   <= HOLD;
                  end else begin
                     state <= ISSUE;
                  end
`else
                  state <= ISSUE;
`endif
               end
            end
            ISSUE: begin
               core_valid <= 1'b1;
               core_din   <= issue_byte;
               wait_cnt   <= '0;
               state      <= WAIT;
            end
            WAIT: begin
               // A result arriving on the last allowed cycle still counts.
               if (core_done) begin
                  m_valid <= 1'b1;
                  m_data  <= core_dout;
                  state   <= HOLD;
               end else if (wait_cnt == CNT_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_ONE;
               end
            end
            HOLD: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_enigma_feeder.sv
// Self-checking bench for enigma_feeder: directed scenarios plus randomized traffic
// against a queue-based reference of byte order and an XOR-cipher core model.
module tb_enigma_feeder;

   localparam int DEPTH = 4;
   localparam int TMO   = 64;
`ifdef ENIGMA_FEEDER_PASSTHRU_EN
   localparam bit PASSTHRU = 1'b1;
`else
   localparam bit PASSTHRU = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_data = 8'h00;
   logic       core_valid;
   logic [7:0] core_din;
   logic       core_done = 1'b0;
   logic [7:0] core_dout = 8'h00;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       busy;
   logic       timeout_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   enigma_feeder #(
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT   (TMO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .core_valid (core_valid),
      .core_din   (core_din),
      .core_done  (core_done),
      .core_dout  (core_dout),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic passes(input logic [7:0] b);
      return PASSTHRU && ((b < 8'h41) || (b > 8'h5A));
   endfunction

   function automatic logic [7:0] cipher(input logic [7:0] b);
      return b ^ 8'h13;
   endfunction

   function automatic logic [7:0] expect_out(input logic [7:0] b);
      return passes(b) ? b : cipher(b);
   endfunction

   // Reference state: bytes accepted but not yet delivered or dropped, oldest first.
   logic [7:0] in_q[$];
   int  cv_cnt = 0;
   int  out_cnt = 0;
   int  lat_cfg = 3;
   bit  mute_cfg = 0;
   bit  rand_core = 0;
   bit  inject = 0;
   bit  exp_err = 0;
   int  doom = 0;
   bit  pend = 0;
   int  pend_cnt = 0;
   logic [7:0] pend_din = 8'h00;
   bit  prev_cv = 0;

   always @(negedge clk) begin : mon
      bit mute;
      int lat;
      core_done = 1'b0;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            core_done = 1'b1;
            core_dout = cipher(pend_din);
            pend = 0;
         end
      end else if (inject) begin
         core_done = 1'b1;
         core_dout = 8'hEE;
      end

      if (doom > 0) begin
         doom--;
         if (doom == 0) begin
            if (in_q.size() != 0) void'(in_q.pop_front());
            exp_err = 1;
         end
      end

      check_val("busy", busy, reset_n && (in_q.size() != 0));
      check_val("timeout_err", timeout_err, exp_err);
      if (!reset_n) check_val("s_ready_rst", s_ready, 0);

      if (core_valid) begin
         cv_cnt++;
         check_val("cv_pulse", prev_cv, 0);
         check_val("cv_in_flight", pend, 0);
         check_val("cv_has_ref", in_q.size() != 0, 1);
         if (in_q.size() != 0) check_val("core_din", core_din, in_q[0]);
         if (rand_core) begin
            mute = ($urandom_range(24) == 0);
            lat  = $urandom_range(6, 1);
         end else begin
            mute = mute_cfg;
            lat  = lat_cfg;
         end
         if (mute) doom = TMO;
         else begin
            pend     = 1;
            pend_cnt = lat;
            pend_din = core_din;
         end
      end else begin
         check_val("din_idle", core_din, 0);
      end
      prev_cv = core_valid;

      if (m_valid) begin
         check_val("m_has_ref", in_q.size() != 0, 1);
         if (in_q.size() != 0) check_val("m_data", m_data, expect_out(in_q[0]));
         if (m_ready && reset_n && in_q.size() != 0) begin
            void'(in_q.pop_front());
            out_cnt++;
         end
      end

      if (s_valid && s_ready) in_q.push_back(s_data);

      if (!reset_n) begin
         in_q.delete();
         doom    = 0;
         exp_err = 0;
         prev_cv = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      logic acc;
      acc = 1'b0;
      s_valid = 1'b1;
      s_data  = b;
      for (int i = 0; i < 300 && !acc; i++) begin
         acc = s_ready;
         tick();
      end
      s_valid = 1'b0;
      check_val("push_accept", acc, 1);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy || m_valid || in_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check_val("drain", !(busy || m_valid || in_q.size() != 0), 1);
   endtask

   initial begin
      int cv_k, mv_k, mv_n, tk, c0, o0, idx, sent;
      logic acc, mv_seen, bz_seen;
      logic nz_cv, nz_mv, nz_busy, nz_err, nz_din, nz_md;
      logic [7:0] burst [5];
      burst[0] = 8'h48; burst[1] = 8'h49; burst[2] = 8'h4A; burst[3] = 8'h4B; burst[4] = 8'h4C;

      // Reset values
      reset_n = 1'b0;
      repeat (3) tick();
      check_val("rst_s_ready", s_ready, 0);
      check_val("rst_core_valid", core_valid, 0);
      check_val("rst_core_din", core_din, 0);
      check_val("rst_m_valid", m_valid, 0);
      check_val("rst_m_data", m_data, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_timeout", timeout_err, 0);
      reset_n = 1'b1;
      tick();
      check_val("post_rst_s_ready", s_ready, 1);

      // Single byte, core answers 3 cycles after issue
      m_ready = 1'b1;
      lat_cfg = 3;
      c0 = cv_cnt;
      push_byte(8'h41);
      cv_k = -1; mv_k = -1; mv_n = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (core_valid && cv_k < 0) cv_k = k;
         if (m_valid) begin
            mv_n++;
            if (mv_k < 0) mv_k = k;
            check_val("m_data_41", m_data, 8'h52);
         end
      end
      check_val("issue_latency", cv_k, 2);
      check_val("result_latency", mv_k, 6);
      check_val("m_valid_cycles", mv_n, 1);
      check_val("cv_pulses_41", cv_cnt - c0, 1);

      // Back-pressure: park one result in HOLD, then burst five bytes
      m_ready = 1'b0;
      o0 = out_cnt;
      push_byte(8'h47);
      for (int i = 0; i < 50 && !m_valid; i++) tick();
      check_val("hold_reached", m_valid, 1);
      idx = 0;
      s_valid = 1'b1;
      for (int i = 0; i < 12 && idx < 5; i++) begin
         s_data = burst[idx];
         acc = s_ready;
         tick();
         if (acc) idx++;
      end
      check_val("burst_accepts", idx, 4);
      check_val("burst_s_ready", s_ready, 0);
      check_val("hold_m_data", m_data, cipher(8'h47));
      m_ready = 1'b1;
      for (int i = 0; i < 60 && idx < 5; i++) begin
         s_data = burst[idx];
         acc = s_ready;
         tick();
         if (acc) idx++;
      end
      s_valid = 1'b0;
      check_val("burst_all", idx, 5);
      wait_idle(300);
      check_val("burst_outputs", out_cnt - o0, 6);

      // Silent core: timeout then normal recovery
      mute_cfg = 1'b1;
      push_byte(8'h55);
      tk = -1; mv_seen = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (timeout_err && tk < 0) tk = k;
         if (m_valid) mv_seen = 1'b1;
      end
      check_val("timeout_latency", tk, 66);
      check_val("timeout_no_m", mv_seen, 0);
      mute_cfg = 1'b0;
      o0 = out_cnt;
      c0 = cv_cnt;
      push_byte(8'h56);
      wait_idle(100);
      check_val("recover_out", out_cnt - o0, 1);
      check_val("recover_cv", cv_cnt - c0, 1);
      check_val("timeout_sticky", timeout_err, 1);

      // Stray core_done while idle
      inject = 1'b1;
      tick();
      inject = 1'b0;
      mv_seen = 1'b0; bz_seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (m_valid) mv_seen = 1'b1;
         if (busy) bz_seen = 1'b1;
      end
      check_val("stray_no_m", mv_seen, 0);
      check_val("stray_idle", bz_seen, 0);

      // Reset during WAIT; the late core result must be ignored
      lat_cfg = 8;
      push_byte(8'h44);
      for (int i = 0; i < 10 && !core_valid; i++) tick();
      check_val("wait_issue", core_valid, 1);
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      nz_cv = 0; nz_mv = 0; nz_busy = 0; nz_err = 0; nz_din = 0; nz_md = 0;
      for (int k = 0; k < 14; k++) begin
         tick();
         nz_cv   |= core_valid;
         nz_mv   |= m_valid;
         nz_busy |= busy;
         nz_err  |= timeout_err;
         nz_din  |= (core_din != 8'h00);
         nz_md   |= (m_data != 8'h00);
      end
      check_val("rstw_core_valid", nz_cv, 0);
      check_val("rstw_m_valid", nz_mv, 0);
      check_val("rstw_busy", nz_busy, 0);
      check_val("rstw_timeout", nz_err, 0);
      check_val("rstw_core_din", nz_din, 0);
      check_val("rstw_m_data", nz_md, 0);
      lat_cfg = 3;

      // Non-letter byte: bypasses the core only when passthrough is built in
      c0 = cv_cnt;
      o0 = out_cnt;
      push_byte(8'h20);
      wait_idle(100);
      check_val("space_cv_pulses", cv_cnt - c0, PASSTHRU ? 0 : 1);
      check_val("space_out", out_cnt - o0, 1);

      // Randomized traffic
      rand_core = 1'b1;
      sent = 0;
      o0 = out_cnt;
      for (int cyc = 0; cyc < 30000 && sent < 150; cyc++) begin
         if (!s_valid && $urandom_range(3) != 0) begin
            s_valid = 1'b1;
            if ($urandom_range(1) == 1) s_data = 8'h41 + 8'($urandom_range(25));
            else s_data = 8'($urandom);
         end
         m_ready = ($urandom_range(2) != 0);
         acc = s_valid && s_ready;
         tick();
         if (acc) begin
            sent++;
            s_valid = 1'b0;
         end
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      check_val("rand_sent", sent, 150);
      wait_idle(3000);
      check_val("rand_some_out", out_cnt - o0 > 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
